// File: rtl/rgb_rx_pkg.sv
// Shared types and constants for the RGB565 LCD timing receiver.
package rgb_rx_pkg;

    localparam int unsigned CW_DEF  = 11;
    localparam int unsigned R_W     = 5;
    localparam int unsigned G_W     = 6;
    localparam int unsigned B_W     = 5;
    localparam int unsigned RGB_W   = R_W + G_W + B_W;
    localparam int unsigned MATCH_W = 3;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/rgb_rx_sync.sv
// Input register stage: polarity-normalised syncs, pixel capture and
// vs-rise / de-fall edge detection.
module rgb_rx_sync
    import rgb_rx_pkg::*;
#(
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0
) (
    input  logic             lcd_clk,
    input  logic             sys_rst_n,
    input  logic             hs_i,
    input  logic             vs_i,
    input  logic             de_i,
    input  logic [RGB_W-1:0] rgb_i,
    output logic             s_hs_o,
    output logic             s_vs_o,
    output logic             s_de_o,
    output rgb565_t          s_rgb_o,
    output logic             vs_rise_c,
    output logic             de_fall_c
);

    logic    s_hs_q;
    logic    s_vs_q;
    logic    s_de_q;
    logic    s_vs_dly_q;
    logic    s_de_dly_q;
    rgb565_t s_rgb_q;

    // XNOR with the active level maps the asserted sync level to 1.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s_hs_q     <= 1'b0;
            s_vs_q     <= 1'b0;
            s_de_q     <= 1'b0;
            s_vs_dly_q <= 1'b0;
            s_de_dly_q <= 1'b0;
            s_rgb_q    <= '0;
        end else begin
            s_hs_q     <= hs_i ~^ HS_POL;
            s_vs_q     <= vs_i ~^ VS_POL;
            s_de_q     <= de_i;
            s_vs_dly_q <= s_vs_q;
            s_de_dly_q <= s_de_q;
            s_rgb_q    <= rgb_i;
        end
    end

    assign s_hs_o    = s_hs_q;
    assign s_vs_o    = s_vs_q;
    assign s_de_o    = s_de_q;
    assign s_rgb_o   = s_rgb_q;
    assign vs_rise_c = s_vs_q & ~s_vs_dly_q;
    assign de_fall_c = ~s_de_q & s_de_dly_q;

endmodule

// File: rtl/rgb_timing_rx.sv
// RGB565 LCD receiver: recovers pixel coordinates and line/frame strobes,
// measures active size and declares lock after consecutive matching frames.
module rgb_timing_rx
    import rgb_rx_pkg::*;
#(
    parameter logic        HS_POL      = 1'b0,
    parameter logic        VS_POL      = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned CW          = CW_DEF
) (
    input  logic             lcd_clk,
    input  logic             sys_rst_n,
    input  logic             vid_hs,
    input  logic             vid_vs,
    input  logic             vid_de,
    input  logic [RGB_W-1:0] vid_rgb,
    output logic             pix_valid,
    output logic [RGB_W-1:0] pix_data,
    output logic [CW-1:0]    pix_xpos,
    output logic [CW-1:0]    pix_ypos,
    output logic             line_start,
    output logic             frame_start,
    output logic [CW-1:0]    h_active,
    output logic [CW-1:0]    v_active,
    output logic             locked,
    output logic             timing_err
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic    hs_unused;
    logic    s_vs;
    logic    s_de;
    rgb565_t s_rgb;
    logic    vs_rise_c;
    logic    de_fall_c;

    rgb_rx_sync #(
        .HS_POL (HS_POL),
        .VS_POL (VS_POL)
    ) u_sync (
        .lcd_clk   (lcd_clk),
        .sys_rst_n (sys_rst_n),
        .hs_i      (vid_hs),
        .vs_i      (vid_vs),
        .de_i      (vid_de),
        .rgb_i     (vid_rgb),
        .s_hs_o    (hs_unused),
        .s_vs_o    (s_vs),
        .s_de_o    (s_de),
        .s_rgb_o   (s_rgb),
        .vs_rise_c (vs_rise_c),
        .de_fall_c (de_fall_c)
    );

    rx_state_e          state_q, state_d;
    logic [CW-1:0]      x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [CW-1:0]      first_w_q, first_w_d, prev_w_q, prev_w_d, prev_h_q, prev_h_d;
    logic               first_seen_q, first_seen_d, bad_frame_q, bad_frame_d;
    logic               de_in_vs_q, de_in_vs_d;
    logic [MATCH_W-1:0] match_q, match_d;

    logic               pix_valid_q, pix_valid_d, line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d, locked_q, locked_d;
    logic               timing_err_q, timing_err_d;
    rgb565_t            pix_data_q, pix_data_d;
    logic [CW-1:0]      pix_xpos_q, pix_xpos_d, pix_ypos_q, pix_ypos_d;
    logic [CW-1:0]      h_active_q, h_active_d, v_active_q, v_active_d;

    logic               run_c, qual_c, emit_c, dv_c, line_end_c, w_mis_c, good_c, same_c;
    logic [MATCH_W-1:0] match_nx_c;

    assign run_c      = (state_q != ST_WAIT_VS);
    assign qual_c     = s_de & ~s_vs;
    assign emit_c     = qual_c & run_c;
    assign dv_c       = s_de & s_vs;
    // A de pulse made only of dropped (vs-overlapped) pixels is not a line.
    assign line_end_c = de_fall_c & ~vs_rise_c & (x_cnt_q != '0);
    assign w_mis_c    = line_end_c & first_seen_q & (x_cnt_q != first_w_q);
    assign good_c     = ~bad_frame_q & ~de_in_vs_q & (y_cnt_q != '0);
    assign same_c     = (first_w_q == prev_w_q) & (y_cnt_q == prev_h_q);
    assign match_nx_c = (good_c & same_c) ? match_q + MATCH_W'(1) : MATCH_W'(good_c);

    always_comb begin
        state_d       = state_q;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        first_w_d     = first_w_q;
        first_seen_d  = first_seen_q;
        bad_frame_d   = bad_frame_q;
        de_in_vs_d    = de_in_vs_q;
        prev_w_d      = prev_w_q;
        prev_h_d      = prev_h_q;
        match_d       = match_q;
        h_active_d    = h_active_q;
        v_active_d    = v_active_q;
        locked_d      = locked_q;
        pix_valid_d   = emit_c;
        pix_data_d    = s_rgb;
        pix_xpos_d    = x_cnt_q;
        pix_ypos_d    = y_cnt_q;
        line_start_d  = emit_c & (x_cnt_q == '0);
        frame_start_d = emit_c & (x_cnt_q == '0) & (y_cnt_q == '0);
        timing_err_d  = run_c & (dv_c | (w_mis_c & ~bad_frame_q));

        if (vs_rise_c) begin
            // Frame boundary: evaluate the closing frame, restart counting.
            x_cnt_d      = '0;
            y_cnt_d      = '0;
            first_seen_d = 1'b0;
            bad_frame_d  = 1'b0;
            de_in_vs_d   = dv_c;
            if (run_c && good_c) begin
                prev_w_d   = first_w_q;
                prev_h_d   = y_cnt_q;
                h_active_d = first_w_q;
                v_active_d = y_cnt_q;
            end
            case (state_q)
                ST_WAIT_VS: begin
                    state_d = ST_MEASURE;
                    match_d = '0;
                end
                ST_MEASURE: begin
                    match_d = match_nx_c;
                    if (32'(match_nx_c) >= LOCK_FRAMES) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!(good_c && same_c)) begin
                        state_d      = ST_MEASURE;
                        locked_d     = 1'b0;
                        timing_err_d = 1'b1;
                        match_d      = MATCH_W'(good_c);
                    end
                end
                default: state_d = ST_WAIT_VS;
            endcase
        end else begin
            if (qual_c && (x_cnt_q != CNT_MAX)) begin
                x_cnt_d = x_cnt_q + CW'(1);
            end
            if (line_end_c) begin
                x_cnt_d = '0;
                if (y_cnt_q != CNT_MAX) begin
                    y_cnt_d = y_cnt_q + CW'(1);
                end
                if (!first_seen_q) begin
                    first_w_d    = x_cnt_q;
                    first_seen_d = 1'b1;
                end else if (w_mis_c) begin
                    bad_frame_d = 1'b1;
                end
            end
            if (dv_c) begin
                de_in_vs_d = 1'b1;
            end
        end
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_WAIT_VS;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            first_w_q     <= '0;
            first_seen_q  <= 1'b0;
            bad_frame_q   <= 1'b0;
            de_in_vs_q    <= 1'b0;
            prev_w_q      <= '0;
            prev_h_q      <= '0;
            match_q       <= '0;
            h_active_q    <= '0;
            v_active_q    <= '0;
            locked_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_xpos_q    <= '0;
            pix_ypos_q    <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            first_w_q     <= first_w_d;
            first_seen_q  <= first_seen_d;
            bad_frame_q   <= bad_frame_d;
            de_in_vs_q    <= de_in_vs_d;
            prev_w_q      <= prev_w_d;
            prev_h_q      <= prev_h_d;
            match_q       <= match_d;
            h_active_q    <= h_active_d;
            v_active_q    <= v_active_d;
            locked_q      <= locked_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_xpos_q    <= pix_xpos_d;
            pix_ypos_q    <= pix_ypos_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            timing_err_q  <= timing_err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_xpos    = pix_xpos_q;
    assign pix_ypos    = pix_ypos_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign h_active    = h_active_q;
    assign v_active    = v_active_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;

endmodule
